mario_motion: RTL

Per-frame player motion controller for the Mario game core. It consumes the 40 Hz frame clock produced by the clock divider and converts it into a one-cycle frame tick in the 12 MHz domain. On each tick it updates Mario's position, vertical velocity, facing and walk-animation frame from the board buttons and the collision flags. Its outputs go to the sprite renderer and the collision lookup.

---
 rtl/mario_pkg.sv | 26 ++
 rtl/tick_sync.sv | 28 ++
 rtl/mario_motion.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mario_pkg.sv
// Shared definitions for the Mario game core: player state encoding,
// screen/sprite geometry and the default motion tuning values.
package mario_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    FALL = 2'd3
  } state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 16;

  localparam int DEF_X_INIT     = 32;
  localparam int DEF_Y_INIT     = 400;
  localparam int DEF_X_MIN      = 0;
  localparam int DEF_X_MAX      = SCREEN_W - SPRITE_W;
  localparam int DEF_Y_FLOOR    = 400;
  localparam int DEF_WALK_SPEED = 2;
  localparam int DEF_JUMP_VEL   = 10;
  localparam int DEF_GRAVITY    = 1;
  localparam int DEF_VMAX_FALL  = 8;

endpackage

// File: rtl/tick_sync.sv
// Two-flop synchroniser for a slow asynchronous clock/level plus a
// rising-edge detector. All flops reset to 1 so that releasing reset while
// the input is high never produces a spurious tick.
module tick_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_tick
);

  logic r_s1, r_s2, r_s3;

  // Synchronise the input and keep one cycle of edge history
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_tick = r_s2 & ~r_s3;

endmodule

// File: rtl/mario_motion.sv
// Per-frame player motion controller. Turns the 40 Hz frame clock into a
// one-cycle tick and, on each tick, advances position, vertical velocity,
// facing and walk animation from the buttons and collision flags.
module mario_motion
  import mario_pkg::*;
#(
  parameter int X_INIT     = DEF_X_INIT,
  parameter int Y_INIT     = DEF_Y_INIT,
  parameter int X_MIN      = DEF_X_MIN,
  parameter int X_MAX      = DEF_X_MAX,
  parameter int Y_FLOOR    = DEF_Y_FLOOR,
  parameter int WALK_SPEED = DEF_WALK_SPEED,
  parameter int JUMP_VEL   = DEF_JUMP_VEL,
  parameter int GRAVITY    = DEF_GRAVITY,
  parameter int VMAX_FALL  = DEF_VMAX_FALL
) (
  input  logic       clk12Mhz,
  input  logic       rst,
  input  logic       clk40Hz,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_jump,
  input  logic       on_ground,
  input  logic       head_hit,
  output logic       frame_tick,
  output logic [9:0] pos_x,
  output logic [8:0] pos_y,
  output logic       facing,
  output logic [1:0] state,
  output logic [1:0] anim_frame
);

  localparam logic [10:0] LP_X_MAX11  = 11'(X_MAX);
  localparam logic [10:0] LP_X_LO11   = 11'(X_MIN + WALK_SPEED);
  localparam logic [10:0] LP_WALK11   = 11'(WALK_SPEED);
  localparam logic [9:0]  LP_WALK10   = 10'(WALK_SPEED);
  localparam logic [9:0]  LP_X_MIN10  = 10'(X_MIN);
  localparam logic [9:0]  LP_X_MAX10  = 10'(X_MAX);
  localparam logic [9:0]  LP_X_INIT   = 10'(X_INIT);
  localparam logic [8:0]  LP_Y_INIT   = 9'(Y_INIT);
  localparam logic [8:0]  LP_Y_FLOOR9 = 9'(Y_FLOOR);
  localparam logic [9:0]  LP_Y_FLOOR10 = 10'(Y_FLOOR);
  localparam logic [3:0]  LP_JUMP_VEL = 4'(JUMP_VEL);
  localparam logic [3:0]  LP_GRAV4    = 4'(GRAVITY);
  localparam logic [4:0]  LP_GRAV5    = 5'(GRAVITY);
  localparam logic [4:0]  LP_VMAX5    = 5'(VMAX_FALL);
  localparam logic [3:0]  LP_VMAX4    = 4'(VMAX_FALL);

  logic       w_tick;
  logic [2:0] r_btn_s1, r_btn_s2;   // {jump, right, left}
  logic       r_frame_tick;
  state_t     r_state, w_state_nxt;
  logic [9:0] r_pos_x, w_x_nxt;
  logic [8:0] r_pos_y, w_y_nxt;
  logic [3:0] r_vy, w_vy_nxt;
  logic       r_facing, w_facing_nxt;
  logic [1:0] r_anim, w_anim_nxt;
  logic       r_armed, w_armed_nxt;

  logic        w_left, w_right, w_walk, w_bj;
  logic        w_on_ground_st, w_jump_start, w_fall_start, w_jump_end;
  logic        w_land_floor, w_land, w_y_up_ok;
  logic [10:0] w_x_inc;
  logic [9:0]  w_x_dec, w_y_dn;
  logic [8:0]  w_y_up;
  logic [4:0]  w_vy_inc;
  logic [3:0]  w_vy_fall, w_vy_up;

  tick_sync u_frame_sync (
    .i_clk   (clk12Mhz),
    .i_rst   (rst),
    .i_async (clk40Hz),
    .o_tick  (w_tick)
  );

  // Bring the asynchronous buttons into the 12 MHz domain
  always_ff @(posedge clk12Mhz or posedge rst) begin
    if (rst) begin
      r_btn_s1 <= 3'b000;
      r_btn_s2 <= 3'b000;
    end else begin
      r_btn_s1 <= {btn_jump, btn_right, btn_left};
      r_btn_s2 <= r_btn_s1;
    end
  end

  assign w_left  = r_btn_s2[0] & ~r_btn_s2[1];
  assign w_right = r_btn_s2[1] & ~r_btn_s2[0];
  assign w_walk  = w_left | w_right;
  assign w_bj    = r_btn_s2[2];

  assign w_on_ground_st = (r_state == IDLE) || (r_state == WALK);
  assign w_jump_start   = w_on_ground_st & w_bj & r_armed;
  assign w_fall_start   = ~on_ground & (r_pos_y < LP_Y_FLOOR9);
  assign w_jump_end     = head_hit | (r_vy <= LP_GRAV4);

  // Saturating arithmetic helpers, widened so nothing wraps before clamping
  assign w_x_inc      = {1'b0, r_pos_x} + LP_WALK11;
  assign w_x_dec      = r_pos_x - LP_WALK10;
  assign w_y_up_ok    = r_pos_y >= {5'b0, r_vy};
  assign w_y_up       = r_pos_y - {5'b0, r_vy};
  assign w_y_dn       = {1'b0, r_pos_y} + {6'b0, r_vy};
  assign w_land_floor = w_y_dn >= LP_Y_FLOOR10;
  assign w_land       = w_land_floor | on_ground;
  assign w_vy_inc     = {1'b0, r_vy} + LP_GRAV5;
  assign w_vy_fall    = (w_vy_inc > LP_VMAX5) ? LP_VMAX4 : w_vy_inc[3:0];
  assign w_vy_up      = r_vy - LP_GRAV4;

  // FSM state register, advanced only on frame ticks
  always_ff @(posedge clk12Mhz or posedge rst) begin
    if (rst)         r_state <= IDLE;
    else if (w_tick) r_state <= w_state_nxt;
  end

  // FSM next-state decision
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, WALK: begin
        if (w_jump_start)      w_state_nxt = JUMP;
        else if (w_fall_start) w_state_nxt = FALL;
        else                   w_state_nxt = w_walk ? WALK : IDLE;
      end
      JUMP: if (w_jump_end) w_state_nxt = FALL;
      FALL: if (w_land)     w_state_nxt = w_walk ? WALK : IDLE;
      default:              w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: next position, velocity, facing, animation and jump arming
  always_comb begin
    w_x_nxt      = r_pos_x;
    w_facing_nxt = r_facing;
    w_y_nxt      = r_pos_y;
    w_vy_nxt     = r_vy;

    if (w_right) begin
      w_x_nxt      = (w_x_inc > LP_X_MAX11) ? LP_X_MAX10 : w_x_inc[9:0];
      w_facing_nxt = 1'b1;
    end else if (w_left) begin
      w_x_nxt      = ({1'b0, r_pos_x} < LP_X_LO11) ? LP_X_MIN10 : w_x_dec;
      w_facing_nxt = 1'b0;
    end

    unique case (r_state)
      IDLE, WALK: begin
        if (w_jump_start)      w_vy_nxt = LP_JUMP_VEL;
        else if (w_fall_start) w_vy_nxt = 4'd0;
      end
      JUMP: begin
        w_y_nxt  = w_y_up_ok ? w_y_up : 9'd0;
        w_vy_nxt = w_jump_end ? 4'd0 : w_vy_up;
      end
      FALL: begin
        if (w_land_floor) begin
          w_y_nxt  = LP_Y_FLOOR9;
          w_vy_nxt = 4'd0;
        end else if (on_ground) begin
          w_vy_nxt = 4'd0;
        end else begin
          w_y_nxt  = w_y_dn[8:0];
          w_vy_nxt = w_vy_fall;
        end
      end
      default: ;
    endcase

    w_anim_nxt = (w_state_nxt == WALK) ? r_anim + 2'd1 : 2'd0;

    if (!w_bj)             w_armed_nxt = 1'b1;
    else if (w_jump_start) w_armed_nxt = 1'b0;
    else                   w_armed_nxt = r_armed;
  end

  // Motion registers, updated only on frame ticks
  always_ff @(posedge clk12Mhz or posedge rst) begin
    if (rst) begin
      r_pos_x  <= LP_X_INIT;
      r_pos_y  <= LP_Y_INIT;
      r_vy     <= 4'd0;
      r_facing <= 1'b1;
      r_anim   <= 2'd0;
      r_armed  <= 1'b0;
    end else if (w_tick) begin
      r_pos_x  <= w_x_nxt;
      r_pos_y  <= w_y_nxt;
      r_vy     <= w_vy_nxt;
      r_facing <= w_facing_nxt;
      r_anim   <= w_anim_nxt;
      r_armed  <= w_armed_nxt;
    end
  end

  // Registered frame pulse, aligned with the motion register update
  always_ff @(posedge clk12Mhz or posedge rst) begin
    if (rst) r_frame_tick <= 1'b0;
    else     r_frame_tick <= w_tick;
  end

  assign frame_tick = r_frame_tick;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign facing     = r_facing;
  assign state      = r_state;
  assign anim_frame = r_anim;

endmodule
